// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The loader writes words of the instruction RAM's column width into its low rows.
package instr_mem_loader_pkg;

    localparam int LOADER_DATA_W = 16;
    localparam int LOADER_ADDR_W = 4;
    localparam int LOADER_DEPTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6
    } loader_state_t;

    // States in which a stream byte can be taken.
    function automatic logic takes_byte(input loader_state_t s);
        return (s == ST_COUNT) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/instr_mem_loader.sv
// Loads a COUNT / word-pairs / XOR-checksum byte stream into the instruction RAM,
// holding the CPU for the duration of the load.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int DATA_W = LOADER_DATA_W,
    parameter int ADDR_W = LOADER_ADDR_W,
    parameter int DEPTH  = LOADER_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_index;
    logic [7:0]        r_hi;
    logic [7:0]        r_csum;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_err;
    logic              w_accept;
    logic [ADDR_W:0]   w_index_inc;

    function automatic logic count_bad(input logic [7:0] n);
        return (n == 8'd0) || (int'(n) > DEPTH);
    endfunction

    assign w_accept    = in_valid && takes_byte(r_state);
    assign w_index_inc = r_index + (ADDR_W+1)'(1);

    // Handshake and status outputs decode straight from the state register.
    assign in_ready = takes_byte(r_state);
    assign wr_en    = (r_state == ST_WRITE);
    assign done     = (r_state == ST_DONE);
    assign cpu_hold = (r_state != ST_IDLE);
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_COUNT;
            ST_COUNT: if (w_accept) w_next = count_bad(in_data) ? ST_IDLE : ST_HI;
            ST_HI:    if (w_accept) w_next = ST_LO;
            ST_LO:    if (w_accept) w_next = ST_WRITE;
            ST_WRITE: w_next = (w_index_inc == r_count) ? ST_CSUM : ST_HI;
            ST_CSUM:  if (w_accept) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_index   <= '0;
            r_hi      <= '0;
            r_csum    <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err   <= 1'b0;
                        r_index <= '0;
                        r_csum  <= '0;
                    end
                end
                ST_COUNT: begin
                    if (w_accept) begin
                        if (count_bad(in_data)) begin
                            r_err <= 1'b1;
                        end else begin
                            r_count <= in_data[ADDR_W:0];
                        end
                    end
                end
                ST_HI: begin
                    if (w_accept) begin
                        r_hi   <= in_data;
                        r_csum <= r_csum ^ in_data;
                    end
                end
                ST_LO: begin
                    // Word and address are staged here so they are stable for the whole write cycle.
                    if (w_accept) begin
                        r_csum    <= r_csum ^ in_data;
                        r_wr_data <= {r_hi, in_data};
                        r_wr_addr <= r_index[ADDR_W-1:0];
                    end
                end
                ST_WRITE: begin
                    r_index <= w_index_inc;
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        r_err <= (in_data != r_csum);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: reset, table of byte streams, mid-load reset.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    int nwr = 0, ndone = 0, nacc = 0, nhold = 0, viol = 0;
    logic [3:0]  wa [0:255];
    logic [15:0] wd [0:255];

    typedef struct {
        int               nb;
        logic [0:33][7:0] b;
        bit               rnd;
        bit               mid_start;
        int               nw;
        logic             exp_err;
        logic             exp_done;
        int               exp_hold;
    } vec_t;

    vec_t tbl [0:6];

    instr_mem_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            if (nwr < 256) begin
                wa[nwr] = wr_addr;
                wd[nwr] = wr_data;
            end
            nwr++;
        end
        if (done) ndone++;
        if (in_valid && in_ready) nacc++;
        if (cpu_hold) nhold++;
        if (wr_en && in_ready) viol++;
        if (!cpu_hold && in_ready) viol++;
        if (done && !cpu_hold) viol++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that took the byte.
    task automatic push_byte(input logic [7:0] b, input bit rnd, input bit with_start, output bit ok);
        bit v;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid = v;
            in_data  = v ? b : 8'hEE;
            start    = with_start && (t == 0);
            if (v && in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic run_vec(input int k, input vec_t v);
        int  b_wr, b_done, b_acc, b_hold;
        bit  ok;
        b_wr = nwr; b_done = ndone; b_acc = nacc; b_hold = nhold;
        pulse_start();
        check($sformatf("v%0d_err_cleared", k), {31'd0, err}, 32'd0);
        check($sformatf("v%0d_hold_after_start", k), {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < v.nb; i++) begin
            push_byte(v.b[i], v.rnd, v.mid_start && (i == 3), ok);
            if (!ok) begin
                total++; bad++;
                $display("FAIL v%0d_byte%0d: not accepted within 100 cycles", k, i);
                return;
            end
        end
        repeat (6) begin @(posedge clk); #1; end
        check($sformatf("v%0d_nwrites", k), nwr - b_wr, v.nw);
        for (int i = 0; i < v.nw && i < nwr - b_wr; i++) begin
            check($sformatf("v%0d_addr%0d", k, i), {28'd0, wa[b_wr + i]}, i);
            check($sformatf("v%0d_word%0d", k, i), {16'd0, wd[b_wr + i]},
                  {16'd0, v.b[1 + 2*i], v.b[2 + 2*i]});
        end
        check($sformatf("v%0d_done_pulses", k), ndone - b_done, {31'd0, v.exp_done});
        check($sformatf("v%0d_err", k), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("v%0d_accepts", k), nacc - b_acc, v.nb);
        check($sformatf("v%0d_hold_released", k), {31'd0, cpu_hold}, 32'd0);
        if (v.exp_hold >= 0)
            check($sformatf("v%0d_hold_cycles", k), nhold - b_hold, v.exp_hold);
    endtask

    initial begin
        logic [7:0] cs;
        bit         ok;
        int         b_acc;

        rst_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;

        for (int k = 0; k < 7; k++) begin
            tbl[k].nb = 0; tbl[k].b = '0; tbl[k].rnd = 1'b0; tbl[k].mid_start = 1'b0;
            tbl[k].nw = 0; tbl[k].exp_err = 1'b0; tbl[k].exp_done = 1'b0; tbl[k].exp_hold = -1;
        end
        tbl[0].nb = 6; tbl[0].b = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40, {28{8'h00}}};
        tbl[0].nw = 2; tbl[0].exp_done = 1'b1; tbl[0].exp_hold = 9;
        tbl[1].nb = 6; tbl[1].b = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41, {28{8'h00}}};
        tbl[1].nw = 2; tbl[1].exp_done = 1'b1; tbl[1].exp_err = 1'b1; tbl[1].exp_hold = 9;
        tbl[2].nb = 1; tbl[2].b = {8'h00, {33{8'h00}}};
        tbl[2].exp_err = 1'b1; tbl[2].exp_hold = 1;
        tbl[3].nb = 1; tbl[3].b = {8'h11, {33{8'h00}}};
        tbl[3].exp_err = 1'b1; tbl[3].exp_hold = 1;
        tbl[4].nb = 34; tbl[4].b[0] = 8'h10; cs = 8'h00;
        for (int k = 1; k <= 32; k++) begin
            tbl[4].b[k] = 8'(k * 7 + 3);
            cs = cs ^ tbl[4].b[k];
        end
        tbl[4].b[33] = cs;
        tbl[4].nw = 16; tbl[4].exp_done = 1'b1; tbl[4].exp_hold = 51;
        tbl[5].nb = 8; tbl[5].b = {8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h21, {26{8'h00}}};
        tbl[5].rnd = 1'b1; tbl[5].mid_start = 1'b1; tbl[5].nw = 3; tbl[5].exp_done = 1'b1;
        tbl[6].nb = 4; tbl[6].b = {8'h01, 8'h00, 8'hFF, 8'hFF, {30{8'h00}}};
        tbl[6].nw = 1; tbl[6].exp_done = 1'b1; tbl[6].exp_hold = 6;

        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_outputs", {8'd0, wr_en, wr_addr, wr_data, cpu_hold, done, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Bytes offered in IDLE must be ignored.
        b_acc = nacc;
        in_valid = 1'b1; in_data = 8'h77;
        repeat (4) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check("idle_no_accept", nacc - b_acc, 0);
        check("idle_no_hold", {31'd0, cpu_hold}, 32'd0);

        // Reset while waiting for the low byte of the third word.
        pulse_start();
        push_byte(8'h03, 1'b0, 1'b0, ok);
        push_byte(8'h11, 1'b0, 1'b0, ok);
        push_byte(8'h22, 1'b0, 1'b0, ok);
        push_byte(8'h33, 1'b0, 1'b0, ok);
        push_byte(8'h44, 1'b0, 1'b0, ok);
        push_byte(8'h55, 1'b0, 1'b0, ok);
        check("midrst_pre_accept", {31'd0, ok}, 32'd1);
        check("midrst_pre_state", {11'd0, in_ready, cpu_hold, wr_addr, wr_data}, {11'd0, 1'b1, 1'b1, 4'd1, 16'h3344});
        #2 rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_outputs", {8'd0, wr_en, wr_addr, wr_data, cpu_hold, done, err}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_idle", {30'd0, in_ready, cpu_hold}, 32'd0);

        for (int k = 0; k < 7; k++) begin
            run_vec(k, tbl[k]);
        end

        check("handshake_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream from a host link (UART RX or debug port) over a valid/ready handshake.
- Assembles 16-bit instruction words and writes them into the writable instruction RAM at consecutive word addresses starting at 0.
- Holds the CPU while loading, and verifies a trailing XOR checksum before signalling completion.

Parameters:
- DATA_W, 16: instruction word width; equals shared COLS.
- ADDR_W, 4: word address width. The CPU fetches with word index pc[4:1].
- DEPTH, 16: number of writable words; must be at most 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction RAM write strobe.
- wr_addr  out  ADDR_W  word address for the write.
- wr_data  out  DATA_W  instruction word to write.
- cpu_hold  out  1  high while loading; CPU stalls with pc held at 0.
- done  out  1  one-cycle pulse at end of a load.
- err  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE. All outputs 0: in_ready, wr_en, wr_addr, wr_data, cpu_hold, done, err. Internal count, index, high byte and checksum cleared.
- Byte accept: a byte is taken on a rising edge with in_valid && in_ready. in_ready is a registered function of state only; it does not depend on in_valid.
- Stream format: COUNT byte N, then N words sent high byte first, then CSUM byte. CSUM is the XOR of every data byte; the COUNT byte is excluded.
- IDLE: in_ready=0, cpu_hold=0.
  - start=1: clear err, index and checksum; go to COUNT; cpu_hold=1 from the next cycle.
  - Bytes presented in IDLE are never accepted.
- COUNT: in_ready=1.
  - On accept with N==0 or N>DEPTH: err=1, no writes, go to IDLE with cpu_hold=0 and no done pulse.
  - Otherwise latch N and go to HI.
- HI: in_ready=1. On accept, store the high byte, XOR it into the checksum, go to LO.
- LO: in_ready=1. On accept, XOR into the checksum. On the next cycle:
  - wr_en=1 for exactly one cycle.
  - wr_addr = index, wr_data = {high byte, low byte}.
  - The word becomes visible to the RAM at the edge ending that cycle.
  - index increments after the write.
  - If index+1==N go to CSUM, else go to HI.
  - in_ready is 0 during the write cycle. Throughput is at most one word per 3 cycles.
- CSUM: in_ready=1. On accept, err = (byte != checksum). Go to DONE.
- DONE: exactly one cycle.
  - done=1, cpu_hold is still 1; cpu_hold drops to 0 the next cycle.
  - Return to IDLE. err holds its value until the next start.
- start while not in IDLE is ignored.
- Index never wraps: N<=DEPTH bounds it. wr_addr holds its last value between writes.
- Words beyond N are left unmodified; the loader never clears RAM.
- rst_n asserted mid-load: immediate return to reset values. Partially written RAM contents are left as-is, and the CPU is released.

Decomposition:
- Shared params file, alongside the existing memory constants COLS and ROWS_I:
  - Loader states IDLE, COUNT, HI, LO, WRITE, CSUM, DONE as `define constants (3-bit encoding).
  - LOADER_ADDR_W.
- The instruction RAM itself is the existing instruction memory converted to a write port: synchronous write with wr_en, wr_addr, wr_data, and the same combinational read on pc[4:1]. It is not part of this block.
- No sub-module is needed. Byte assembly and checksum are a few registers inside the FSM.

Test Plan:
- Reset mid-stream: assert rst_n low while in LO -> all outputs 0 within the same cycle (asynchronous). After release, state is IDLE and a fresh start loads normally.
- Normal load: start, then bytes 02, 12, 34, AB, CD, CSUM=0x40 (0x12^0x34^0xAB^0xCD) ->
  - wr_en pulses at (addr 0, 0x1234) and (addr 1, 0xABCD).
  - done pulses once, err=0.
  - cpu_hold is high from the cycle after start through the done cycle.
- Bad checksum: same stream with CSUM=0x41 -> both writes occur, done pulses, err=1 and stays 1 until the next start.
- Count bounds: COUNT=00 and COUNT=17 (decimal 17 > DEPTH) -> err=1, no wr_en, no done, cpu_hold=0. COUNT=16 with 32 data bytes -> last write at addr 15, no wrap.
- Handshake: in_valid toggling randomly, plus start asserted during a load -> every byte is accepted exactly once, the second start is ignored, and in_ready stays 0 in IDLE and in the write cycle.
